nios2_sopc_mmu_tlb_ctrl: RTL and testbench

Port-2 controller for the 256 x 32 MMU TLB RAM in the Nios II SOPC. Shares the RAM's second port between two requesters: a host configuration slave and an internal flush engine. The flush engine writes an invalid-entry word over a programmable, possibly wrapping, address range. Port 1 stays with the CPU and is not touched by this block.

---
 rtl/nios2_sopc_mmu_pkg.sv | 18 +
 rtl/nios2_sopc_mmu_rr_arb2.sv | 46 ++++
 rtl/nios2_sopc_mmu_tlb_ctrl.sv | 137 +++++++++++++
 tb/tb_nios2_sopc_mmu_tlb_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_sopc_mmu_pkg.sv
// -----------------------------------------------------------------------------
// nios2_sopc_mmu_pkg
// Shared definitions for the MMU TLB port-2 controller: default RAM geometry,
// the word written by the flush engine, and the flush FSM state encoding.
// -----------------------------------------------------------------------------
package nios2_sopc_mmu_pkg;

  localparam int          ADDR_W_DEF       = 8;
  localparam int          DATA_W_DEF       = 32;
  localparam logic [31:0] INVALID_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/nios2_sopc_mmu_rr_arb2.sv
// -----------------------------------------------------------------------------
// nios2_sopc_mmu_rr_arb2
// Two-requester arbiter. A lone requester always wins; when both request,
// the grant alternates based on who won the previous contested cycle.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   clear           forces the alternation history back to "host went last"
//   req_host        host configuration slave request
//   req_flush       flush engine request
//   gnt_host        grant to host      (one-hot with gnt_flush, or both zero)
//   gnt_flush       grant to flush engine
// -----------------------------------------------------------------------------
module nios2_sopc_mmu_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic req_host,
  input  logic req_flush,
  output logic gnt_host,
  output logic gnt_flush
);

  logic last_was_flush;
  logic contested;

  assign contested = req_host & req_flush;

  // When contested, the flush engine wins unless it also won last time.
  assign gnt_flush = req_flush & (~req_host | ~last_was_flush);
  assign gnt_host  = req_host  & (~req_flush | last_was_flush);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_was_flush <= 1'b0;
    end else if (clear) begin
      last_was_flush <= 1'b0;
    end else if (contested) begin
      // History only moves on contested cycles; lone grants leave it alone.
      last_was_flush <= gnt_flush;
    end
  end

endmodule

// File: rtl/nios2_sopc_mmu_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// nios2_sopc_mmu_tlb_ctrl
// Port-2 controller for the MMU TLB RAM. Shares RAM port 2 between the host
// configuration slave and a flush engine that writes INVALID_WORD over a
// programmable (possibly wrapping) inclusive address range.
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   hs_read/hs_write             host requests (mutually exclusive)
//   hs_address/_writedata/_byteenable  host transfer fields
//   hs_waitrequest               host request not accepted this cycle
//   hs_readdata/_readdatavalid   read return, one cycle after the grant
//   flush_start                  pulse; samples flush_first/flush_last
//   flush_busy/flush_done        flush in progress / one-cycle completion pulse
//   ram_*2                       RAM port-2 control and data
// -----------------------------------------------------------------------------
module nios2_sopc_mmu_tlb_ctrl
  import nios2_sopc_mmu_pkg::*;
#(
  parameter int                 ADDR_W       = ADDR_W_DEF,
  parameter int                 DATA_W       = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  INVALID_WORD = INVALID_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hs_read,
  input  logic              hs_write,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_writedata,
  input  logic [3:0]        hs_byteenable,
  output logic              hs_waitrequest,
  output logic [DATA_W-1:0] hs_readdata,
  output logic              hs_readdatavalid,
  input  logic              flush_start,
  input  logic [ADDR_W-1:0] flush_first,
  input  logic [ADDR_W-1:0] flush_last,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [ADDR_W-1:0] ram_address2,
  output logic              ram_chipselect2,
  output logic              ram_write2,
  output logic [DATA_W-1:0] ram_writedata2,
  output logic [3:0]        ram_byteenable2,
  output logic              ram_clken2,
  input  logic [DATA_W-1:0] ram_readdata2
);

  flush_state_e      state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] end_addr;
  logic              rd_valid;
  logic              host_req;
  logic              req_host;
  logic              req_flush;
  logic              gnt_host;
  logic              gnt_flush;
  logic              load_range;

  assign host_req   = hs_read | hs_write;
  // No grant while reset is held, so nothing reaches the RAM during reset.
  assign req_host   = host_req & ~reset;
  assign req_flush  = (state == ST_FLUSH) & ~reset;
  assign load_range = (state == ST_IDLE) & flush_start;

  nios2_sopc_mmu_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_range),
    .req_host  (req_host),
    .req_flush (req_flush),
    .gnt_host  (gnt_host),
    .gnt_flush (gnt_flush)
  );

  assign hs_waitrequest   = host_req & ~gnt_host;
  assign hs_readdata      = ram_readdata2;
  assign hs_readdatavalid = rd_valid;
  assign flush_busy       = (state != ST_IDLE);
  assign flush_done       = (state == ST_DONE);
  assign ram_clken2       = 1'b1;

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ram_address2    = '0;
    ram_chipselect2 = 1'b0;
    ram_write2      = 1'b0;
    ram_writedata2  = '0;
    ram_byteenable2 = 4'h0;
    if (gnt_host) begin
      ram_address2    = hs_address;
      ram_chipselect2 = 1'b1;
      ram_write2      = hs_write;
      ram_writedata2  = hs_writedata;
      ram_byteenable2 = hs_byteenable;
    end else if (gnt_flush) begin
      ram_address2    = ptr;
      ram_chipselect2 = 1'b1;
      ram_write2      = 1'b1;
      ram_writedata2  = INVALID_WORD;
      ram_byteenable2 = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      end_addr <= '0;
      rd_valid <= 1'b0;
    end else begin
      // The RAM registers the address at the end of the grant cycle, so its
      // data appears on ram_readdata2 one cycle later.
      rd_valid <= gnt_host & hs_read;
      case (state)
        ST_IDLE: begin
          if (flush_start) begin
            state    <= ST_FLUSH;
            ptr      <= flush_first;
            end_addr <= flush_last;
          end
        end
        ST_FLUSH: begin
          if (gnt_flush) begin
            // Compare before incrementing so a wrapping range and the
            // full-table case (last = first - 1) terminate correctly.
            if (ptr == end_addr) state <= ST_DONE;
            else                 ptr   <= ptr + ADDR_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_sopc_mmu_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nios2_sopc_mmu_tlb_ctrl
// Bench for the TLB port-2 controller paired with a 256 x 32 byte-enabled RAM
// model (address registered on the clock, data one cycle later). A shadow
// array holds the expected RAM contents; flush results are read back through
// the host port and compared against it.
// -----------------------------------------------------------------------------
module tb_nios2_sopc_mmu_tlb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        hs_read, hs_write;
  logic [7:0]  hs_address;
  logic [31:0] hs_writedata;
  logic [3:0]  hs_byteenable;
  logic        hs_waitrequest;
  logic [31:0] hs_readdata;
  logic        hs_readdatavalid;
  logic        flush_start;
  logic [7:0]  flush_first, flush_last;
  logic        flush_busy, flush_done;
  logic [7:0]  ram_address2;
  logic        ram_chipselect2, ram_write2, ram_clken2;
  logic [31:0] ram_writedata2, ram_readdata2;
  logic [3:0]  ram_byteenable2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ram   [256];
  logic [31:0] model [256];

  always #5 clk = ~clk;

  nios2_sopc_mmu_tlb_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .hs_read          (hs_read),
    .hs_write         (hs_write),
    .hs_address       (hs_address),
    .hs_writedata     (hs_writedata),
    .hs_byteenable    (hs_byteenable),
    .hs_waitrequest   (hs_waitrequest),
    .hs_readdata      (hs_readdata),
    .hs_readdatavalid (hs_readdatavalid),
    .flush_start      (flush_start),
    .flush_first      (flush_first),
    .flush_last       (flush_last),
    .flush_busy       (flush_busy),
    .flush_done       (flush_done),
    .ram_address2     (ram_address2),
    .ram_chipselect2  (ram_chipselect2),
    .ram_write2       (ram_write2),
    .ram_writedata2   (ram_writedata2),
    .ram_byteenable2  (ram_byteenable2),
    .ram_clken2       (ram_clken2),
    .ram_readdata2    (ram_readdata2)
  );

  // RAM port-2 model: old data on read-during-write, byte-lane writes.
  always @(posedge clk) begin
    if (ram_chipselect2 && ram_clken2) begin
      if (ram_write2)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable2[b]) ram[ram_address2][8*b +: 8] <= ram_writedata2[8*b +: 8];
      ram_readdata2 <= ram[ram_address2];
    end
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    hs_write = 1'b1; hs_address = a; hs_writedata = d; hs_byteenable = be;
    #1;
    while (hs_waitrequest && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("wr_grant", hs_waitrequest, 0);
    @(posedge clk); #1;
    hs_write = 1'b0;
    for (int b = 0; b < 4; b++)
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    hs_read = 1'b1; hs_address = a;
    #1;
    while (hs_waitrequest && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("rd_grant", hs_waitrequest, 0);
    @(negedge clk);
    hs_read = 1'b0;
    #1;
    check("rd_valid_n1", hs_readdatavalid, 1);
    d = hs_readdata;
    @(negedge clk); #1;
    check("rd_valid_n2", hs_readdatavalid, 0);
  endtask

  task automatic preload(input logic [15:0] salt);
    for (int a = 0; a < 256; a++) host_write(8'(a), {salt, 8'h5A, 8'(a)}, 4'hF);
  endtask

  task automatic verify_all(input string name);
    logic [31:0] d;
    for (int a = 0; a < 256; a++) begin
      host_read(8'(a), d);
      check($sformatf("%s[%0d]", name, a), d, model[a]);
    end
  endtask

  // Runs a flush with no host traffic. restart_at > 0 pulses flush_start with
  // a different range in that cycle, which must be ignored.
  task automatic run_flush(input logic [7:0] f, input logic [7:0] l, input int restart_at);
    logic [7:0] span;
    logic [7:0] exp_addr;
    int n_exp, writes, done_cyc, done_cnt;
    span = l - f;
    n_exp = int'(span) + 1;
    exp_addr = f;
    writes = 0; done_cyc = 0; done_cnt = 0;
    @(negedge clk);
    flush_first = f; flush_last = l; flush_start = 1'b1;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(negedge clk);
      flush_start = (cyc == restart_at);
      if (cyc == restart_at) begin
        flush_first = 8'd100; flush_last = 8'd200;
      end
      #1;
      if (cyc == 1) check("flush_busy_on", flush_busy, 1);
      if (ram_chipselect2 && ram_write2) begin
        check($sformatf("flush_addr_%0d", writes), ram_address2, exp_addr);
        check("flush_data", {ram_byteenable2, ram_writedata2[27:0]}, {4'hF, 28'h0});
        exp_addr++;
        writes++;
      end
      if (flush_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 4) break;
    end
    check("flush_done_cycle", done_cyc, n_exp + 1);
    check("flush_writes", writes, n_exp);
    check("flush_done_count", done_cnt, 1);
    check("flush_busy_off", flush_busy, 0);
    for (int k = 0; k < n_exp; k++) model[8'(int'(f) + k)] = 32'h0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_pend;
    logic        pend;
    int          j;

    vecs[0]  = '{1'b1, 8'd7,   32'h1234_5678, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 8'd7,   32'h0,         4'h0, 32'h1234_5678};
    vecs[2]  = '{1'b1, 8'd7,   32'hDEAD_BEEF, 4'h3, 32'h0};
    vecs[3]  = '{1'b0, 8'd7,   32'h0,         4'h0, 32'h1234_BEEF};
    vecs[4]  = '{1'b1, 8'd8,   32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 8'd8,   32'h0000_0000, 4'h8, 32'h0};
    vecs[6]  = '{1'b1, 8'd8,   32'h1122_3344, 4'h4, 32'h0};
    vecs[7]  = '{1'b0, 8'd8,   32'h0,         4'h0, 32'h0022_FFFF};
    vecs[8]  = '{1'b1, 8'd0,   32'hA5A5_0001, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 8'd255, 32'h0BAD_F00D, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 8'd0,   32'h0,         4'h0, 32'hA5A5_0001};
    vecs[11] = '{1'b0, 8'd255, 32'h0,         4'h0, 32'h0BAD_F00D};

    reset = 1'b1; hs_read = 1'b0; hs_write = 1'b1; hs_address = 8'd3;
    hs_writedata = 32'h0; hs_byteenable = 4'hF;
    flush_start = 1'b0; flush_first = 8'd0; flush_last = 8'd0;

    // Reset state, with a host write held to show no grant during reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst_waitrequest", hs_waitrequest, 1);
    check("rst_busy", flush_busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_rdvalid", hs_readdatavalid, 0);
    check("rst_cs", ram_chipselect2, 0);
    check("rst_write", ram_write2, 0);
    check("rst_addr", ram_address2, 0);
    check("rst_clken", ram_clken2, 1);
    @(negedge clk);
    hs_write = 1'b0; reset = 1'b0;

    // Table-driven host writes/reads, including partial byte lanes.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) host_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      else begin
        host_read(vecs[i].addr, d);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      end
    end

    // Full-table flush with no host traffic.
    preload(16'hC0DE);
    run_flush(8'd0, 8'd255, 0);
    verify_all("full_flush");

    // Wrapping flush 250..3.
    preload(16'hBEE5);
    run_flush(8'd250, 8'd3, 0);
    verify_all("wrap_flush");

    // Full flush with continuous host reads: strict alternation.
    preload(16'h7E57);
    @(negedge clk);
    flush_first = 8'd0; flush_last = 8'd255; flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0; hs_read = 1'b1; hs_address = 8'd128;
    j = 0; pend = 1'b0; exp_pend = 32'h0;
    for (int c = 1; c <= 512; c++) begin
      #1;
      check($sformatf("alt_rdvalid_c%0d", c), hs_readdatavalid, pend);
      if (pend) check($sformatf("alt_rdata_c%0d", c), hs_readdata, exp_pend);
      check($sformatf("alt_wait_c%0d", c), hs_waitrequest, (c < 512) && (c % 2 == 1));
      check($sformatf("alt_done_c%0d", c), flush_done, c == 512);
      pend = !hs_waitrequest;
      if (pend) exp_pend = (int'(hs_address) <= j) ? 32'h0 : model[hs_address];
      @(negedge clk);
      if (pend) begin
        hs_address = hs_address + 8'd1;
        j++;
      end
    end
    hs_read = 1'b0;
    #1;
    check("alt_rdvalid_tail", hs_readdatavalid, pend);
    if (pend) check("alt_rdata_tail", hs_readdata, exp_pend);
    check("alt_busy_off", flush_busy, 0);
    for (int a = 0; a < 256; a++) model[a] = 32'h0;
    verify_all("alt_flush");

    // flush_start pulsed mid-flush with another range is ignored.
    preload(16'h5AFE);
    run_flush(8'd10, 8'd19, 3);
    verify_all("restart_flush");

    // Reset at the 5th flush write aborts without flush_done.
    preload(16'h0F0F);
    @(negedge clk);
    flush_first = 8'd40; flush_last = 8'd60; flush_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      flush_start = 1'b0;
      #1;
      check($sformatf("abort_wr_%0d", c), {ram_chipselect2, ram_write2, ram_address2}, {2'b11, 8'(39 + c)});
    end
    @(negedge clk);
    reset = 1'b1; hs_write = 1'b1; hs_address = 8'd200; hs_writedata = 32'h0; hs_byteenable = 4'hF;
    #1;
    check("abort_no_grant", ram_chipselect2, 0);
    check("abort_wait", hs_waitrequest, 1);
    @(negedge clk);
    reset = 1'b0; hs_write = 1'b0;
    #1;
    check("abort_busy", flush_busy, 0);
    check("abort_done", flush_done, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("abort_no_done", flush_done | flush_busy, 0);
    end
    for (int a = 40; a < 44; a++) model[a] = 32'h0;
    verify_all("abort");
    run_flush(8'd44, 8'd45, 0);
    verify_all("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
